// File: rtl/cv32e40s_ctrl_scoreboard.sv
// In-order write scoreboard for ID hazard detection: RAW/WAW stalls and WB-retire forward select.
// Latency: pushes are visible to hazard checks next cycle; a retiring head stops counting the same cycle.
// Backpressure: issue_ready_o = !full only; a push while full is dropped and sets the sticky err_o.
module cv32e40s_ctrl_scoreboard #(
    parameter int unsigned DEPTH                  = 4,
    parameter int unsigned REGFILE_NUM_READ_PORTS = 2,
    parameter int unsigned ADDR_W                 = 5
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     issue_valid_i,
    input  logic                                     issue_we_i,
    input  logic [ADDR_W-1:0]                        issue_waddr_i,
    output logic                                     issue_ready_o,
    input  logic                                     retire_valid_i,
    output logic [ADDR_W-1:0]                        retire_waddr_o,
    input  logic                                     kill_i,
    input  logic [REGFILE_NUM_READ_PORTS-1:0]        rf_re_i,
    input  logic [REGFILE_NUM_READ_PORTS*ADDR_W-1:0] rf_raddr_i,
    output logic                                     raw_stall_o,
    output logic                                     waw_stall_o,
    output logic [REGFILE_NUM_READ_PORTS-1:0]        fwd_wb_o,
    output logic [$clog2(DEPTH+1)-1:0]               count_o,
    output logic                                     empty_o,
    output logic                                     full_o,
    output logic                                     err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    // Entry storage; entry_vld_q marks occupied slots between rd and wr pointers
    logic [DEPTH-1:0]  entry_vld_q;
    logic [DEPTH-1:0]  entry_we_q;
    logic [ADDR_W-1:0] entry_waddr_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  live;
    logic              head_we;
    logic [ADDR_W-1:0] head_waddr;
    logic              waw_hit;

    logic [REGFILE_NUM_READ_PORTS-1:0] port_raw;
    logic [REGFILE_NUM_READ_PORTS-1:0] port_fwd;

    // Occupancy flags and the qualified push/pop strobes; kill swallows both
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        push  = issue_valid_i && !full && !kill_i;
        pop   = retire_valid_i && !empty && !kill_i;
    end

    // Head view; a retiring head is dropped from the live set so it no longer stalls
    always_comb begin
        head_we    = entry_vld_q[rd_ptr_q] & entry_we_q[rd_ptr_q];
        head_waddr = entry_waddr_q[rd_ptr_q];
        live       = entry_vld_q & entry_we_q;
        if (retire_valid_i) begin
            live[rd_ptr_q] = 1'b0;
        end
    end

    // Per read port: RAW against live writers, else forward from the retiring head
    for (genvar p = 0; p < REGFILE_NUM_READ_PORTS; p++) begin : g_port
        logic [ADDR_W-1:0] raddr;
        logic              live_hit;

        assign raddr = rf_raddr_i[p*ADDR_W +: ADDR_W];

        // Any live writer targeting this port's source register
        always_comb begin
            live_hit = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (live[i] && (entry_waddr_q[i] == raddr)) begin
                    live_hit = 1'b1;
                end
            end
        end

        // A younger live writer takes priority over the retiring one: stall, not forward
        assign port_raw[p] = rf_re_i[p] && (raddr != '0) && live_hit;
        assign port_fwd[p] = retire_valid_i && head_we && (head_waddr == raddr) &&
                             rf_re_i[p] && (raddr != '0) && !live_hit;
    end

    // WAW: issuing destination already owned by a live writer (advisory only)
    always_comb begin
        waw_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (entry_waddr_q[i] == issue_waddr_i)) begin
                waw_hit = 1'b1;
            end
        end
    end

    // Output drive; hazard outputs are muted while the pipeline is being killed
    always_comb begin
        issue_ready_o  = !full;
        empty_o        = empty;
        full_o         = full;
        count_o        = count_q;
        err_o          = err_q;
        retire_waddr_o = empty ? '0 : head_waddr;
        raw_stall_o    = !kill_i && (|port_raw);
        fwd_wb_o       = kill_i ? '0 : port_fwd;
        waw_stall_o    = !kill_i && issue_valid_i && issue_we_i &&
                         (issue_waddr_i != '0) && waw_hit;
    end

    // Entry payload; x0 writers are tracked for ordering but never marked as writing
    always_ff @(posedge clk) begin
        if (push) begin
            entry_we_q[wr_ptr_q]    <= issue_we_i && (issue_waddr_i != '0);
            entry_waddr_q[wr_ptr_q] <= issue_waddr_i;
        end
    end

    // Pointers, count, valid bits and the sticky misuse flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            entry_vld_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (!kill_i && ((retire_valid_i && empty) || (issue_valid_i && full))) begin
                err_q <= 1'b1;
            end
            if (kill_i) begin
                rd_ptr_q    <= '0;
                wr_ptr_q    <= '0;
                count_q     <= '0;
                entry_vld_q <= '0;
            end else begin
                if (push) begin
                    entry_vld_q[wr_ptr_q] <= 1'b1;
                    wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    entry_vld_q[rd_ptr_q] <= 1'b0;
                    rd_ptr_q              <= rd_ptr_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cv32e40s_ctrl_scoreboard.sv
// Directed-vector bench for cv32e40s_ctrl_scoreboard with a queued expectation monitor.
// Latency: inputs driven 1ns after posedge, outputs compared on the following negedge.
// Backpressure: none modelled beyond issue_ready_o checks.
module tb_cv32e40s_ctrl_scoreboard;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_we;
    logic [4:0] issue_waddr;
    logic       issue_ready;
    logic       retire_valid;
    logic [4:0] retire_waddr;
    logic       kill;
    logic [1:0] rf_re;
    logic [9:0] rf_raddr;
    logic       raw_stall;
    logic       waw_stall;
    logic [1:0] fwd_wb;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       err;

    typedef struct {
        string      name;
        logic [2:0] cnt;
        logic       raw;
        logic       waw;
        logic [1:0] fwd;
        logic [4:0] rwa;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    cv32e40s_ctrl_scoreboard #(
        .DEPTH(4),
        .REGFILE_NUM_READ_PORTS(2),
        .ADDR_W(5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid),
        .issue_we_i    (issue_we),
        .issue_waddr_i (issue_waddr),
        .issue_ready_o (issue_ready),
        .retire_valid_i(retire_valid),
        .retire_waddr_o(retire_waddr),
        .kill_i        (kill),
        .rf_re_i       (rf_re),
        .rf_raddr_i    (rf_raddr),
        .raw_stall_o   (raw_stall),
        .waw_stall_o   (waw_stall),
        .fwd_wb_o      (fwd_wb),
        .count_o       (count),
        .empty_o       (empty),
        .full_o        (full),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0d expected=%0d", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "count",        int'(count),        int'(e.cnt));
                chk(e.name, "empty",        int'(empty),        int'(e.cnt == 3'd0));
                chk(e.name, "full",         int'(full),         int'(e.cnt == 3'd4));
                chk(e.name, "issue_ready",  int'(issue_ready),  int'(e.cnt != 3'd4));
                chk(e.name, "raw_stall",    int'(raw_stall),    int'(e.raw));
                chk(e.name, "waw_stall",    int'(waw_stall),    int'(e.waw));
                chk(e.name, "fwd_wb",       int'(fwd_wb),       int'(e.fwd));
                chk(e.name, "retire_waddr", int'(retire_waddr), int'(e.rwa));
                chk(e.name, "err",          int'(err),          int'(e.err));
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during that cycle
    task automatic step(input string nm, input logic rs, input logic iv, input logic iwe,
                        input logic [4:0] ia, input logic rv, input logic kl,
                        input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic [2:0] ecnt, input logic eraw, input logic ewaw,
                        input logic [1:0] efwd, input logic [4:0] erwa, input logic eerr);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = rs;
        issue_valid  = iv;
        issue_we     = iwe;
        issue_waddr  = ia;
        retire_valid = rv;
        kill         = kl;
        rf_re        = re;
        rf_raddr     = {ra1, ra0};
        e.name = nm;
        e.cnt  = ecnt;
        e.raw  = eraw;
        e.waw  = ewaw;
        e.fwd  = efwd;
        e.rwa  = erwa;
        e.err  = eerr;
        exp_q.push_back(e);
    endtask

    logic [4:0] wrap_head [5] = '{5'd11, 5'd12, 5'd13, 5'd20, 5'd21};

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_we = 1'b0; issue_waddr = '0;
        retire_valid = 1'b0; kill = 1'b0; rf_re = '0; rf_raddr = '0;
        repeat (2) @(posedge clk);

        //   name         rs iv we ia    rv kl re     ra0    ra1    cnt raw waw fwd    rwa    err
        step("reset",     0, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        // reset mid-stream
        step("rs_i1",     0, 1, 1, 5'd1, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        step("rs_i2",     0, 1, 1, 5'd2, 0, 0, 2'b00, 5'd0,  5'd0,  1,  0,  0,  2'b00, 5'd1,  0);
        step("rs_i3",     0, 1, 1, 5'd3, 0, 0, 2'b00, 5'd0,  5'd0,  2,  0,  0,  2'b00, 5'd1,  0);
        step("rs_assert", 1, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  3,  0,  0,  2'b00, 5'd1,  0);
        step("rs_after",  0, 0, 0, 5'd0, 0, 0, 2'b01, 5'd1,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        // RAW then forward from retiring head
        step("raw_i5",    0, 1, 1, 5'd5, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        step("raw_x5",    0, 0, 0, 5'd0, 0, 0, 2'b01, 5'd5,  5'd0,  1,  1,  0,  2'b00, 5'd5,  0);
        step("fwd_x5",    0, 0, 0, 5'd0, 1, 0, 2'b01, 5'd5,  5'd0,  1,  0,  0,  2'b01, 5'd5,  0);
        step("fwd_done",  0, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        // younger writer wins over retiring one
        step("yw_i7a",    0, 1, 1, 5'd7, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        step("yw_i7b",    0, 1, 1, 5'd7, 0, 0, 2'b00, 5'd0,  5'd0,  1,  0,  1,  2'b00, 5'd7,  0);
        step("yw_ret1",   0, 0, 0, 5'd0, 1, 0, 2'b10, 5'd0,  5'd7,  2,  1,  0,  2'b00, 5'd7,  0);
        step("yw_ret2",   0, 0, 0, 5'd0, 1, 0, 2'b10, 5'd0,  5'd7,  1,  0,  0,  2'b10, 5'd7,  0);
        // retire while empty sets err; only rst clears it
        step("er_ret",    0, 0, 0, 5'd0, 1, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        step("er_set",    0, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  1);
        step("er_rst",    1, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  1);
        step("er_clr",    0, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        // fill to full, then push+pop while full
        step("fl_i10",    0, 1, 1, 5'd10,0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        step("fl_i11",    0, 1, 1, 5'd11,0, 0, 2'b00, 5'd0,  5'd0,  1,  0,  0,  2'b00, 5'd10, 0);
        step("fl_i12",    0, 1, 1, 5'd12,0, 0, 2'b00, 5'd0,  5'd0,  2,  0,  0,  2'b00, 5'd10, 0);
        step("fl_i13",    0, 1, 1, 5'd13,0, 0, 2'b00, 5'd0,  5'd0,  3,  0,  0,  2'b00, 5'd10, 0);
        step("fl_full",   0, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  4,  0,  0,  2'b00, 5'd10, 0);
        step("fl_pp",     0, 1, 1, 5'd14,1, 0, 2'b00, 5'd0,  5'd0,  4,  0,  0,  2'b00, 5'd10, 0);
        step("fl_after",  0, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  3,  0,  0,  2'b00, 5'd11, 1);
        // alternating push/pop across pointer wrap; head follows issue order
        for (int k = 0; k < 5; k++) begin
            step($sformatf("wr_push%0d", k), 0, 1, 1, 5'(20 + k), 0, 0, 2'b00, 5'd0, 5'd0,
                 3, 0, 0, 2'b00, wrap_head[k], 1);
            step($sformatf("wr_pop%0d", k),  0, 0, 0, 5'd0, 1, 0, 2'b00, 5'd0, 5'd0,
                 4, 0, 0, 2'b00, wrap_head[k], 1);
        end
        step("dr_pop22",  0, 0, 0, 5'd0, 1, 0, 2'b00, 5'd0,  5'd0,  3,  0,  0,  2'b00, 5'd22, 1);
        step("dr_pop23",  0, 0, 0, 5'd0, 1, 0, 2'b00, 5'd0,  5'd0,  2,  0,  0,  2'b00, 5'd23, 1);
        step("dr_pop24",  0, 0, 0, 5'd0, 1, 0, 2'b00, 5'd0,  5'd0,  1,  0,  0,  2'b00, 5'd24, 1);
        step("dr_empty",  0, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  1);
        step("dr_rst",    1, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  1);
        // x0 writer never hazards; WAW on repeated destination
        step("x0_i0",     0, 1, 1, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        step("x0_rd",     0, 0, 0, 5'd0, 0, 0, 2'b01, 5'd0,  5'd0,  1,  0,  0,  2'b00, 5'd0,  0);
        step("x0_ret",    0, 0, 0, 5'd0, 1, 0, 2'b01, 5'd0,  5'd0,  1,  0,  0,  2'b00, 5'd0,  0);
        step("waw_i3a",   0, 1, 1, 5'd3, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        step("waw_i3b",   0, 1, 1, 5'd3, 0, 0, 2'b00, 5'd0,  5'd0,  1,  0,  1,  2'b00, 5'd3,  0);
        step("waw_cnt",   0, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  2,  0,  0,  2'b00, 5'd3,  0);
        // non-writing instruction never hazards
        step("nw_i6",     0, 1, 0, 5'd6, 0, 0, 2'b00, 5'd0,  5'd0,  2,  0,  0,  2'b00, 5'd3,  0);
        step("nw_rd6",    0, 0, 0, 5'd0, 0, 0, 2'b01, 5'd6,  5'd0,  3,  0,  0,  2'b00, 5'd3,  0);
        // kill: same-cycle issue/retire discarded, hazards muted
        step("kl_kill",   0, 1, 1, 5'd3, 1, 1, 2'b01, 5'd3,  5'd0,  3,  0,  0,  2'b00, 5'd3,  0);
        step("kl_after",  0, 0, 0, 5'd0, 0, 0, 2'b01, 5'd3,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        step("kl_ret_e",  0, 0, 0, 5'd0, 1, 1, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);
        step("kl_noerr",  0, 0, 0, 5'd0, 0, 0, 2'b00, 5'd0,  5'd0,  0,  0,  0,  2'b00, 5'd0,  0);

        // let the monitor drain, bounded
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
